// File: rtl/background_restore.sv
// Restores a BOX_W x BOX_H rectangle of background pixels by scanning
// the background ROM and replaying each colour to the VGA adapter.
//
// Ports:
//   clock, resetn       : system clock, asynchronous active-low reset
//   start, x0, y0       : restore request and box top-left corner
//   rom_x, rom_y, rom_q : background ROM address out, colour back (1 clk)
//   vga_x, vga_y        : pixel coordinate to the VGA adapter
//   vga_colour, plot    : pixel colour and write strobe
//   busy, done          : in-progress flag and completion pulse
module background_restore #(
    parameter int BOX_W = 16,
    parameter int BOX_H = 12,
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [8:0] x0,
    input  logic [7:0] y0,
    output logic [8:0] rom_x,
    output logic [7:0] rom_y,
    input  logic [2:0] rom_q,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int CXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int CYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    localparam logic [CXW-1:0] CX_LAST = CXW'(BOX_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(BOX_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [8:0]     x0_l;
    logic [8:0]     x0_l_nxt;
    logic [7:0]     y0_l;
    logic [7:0]     y0_l_nxt;
    logic [CXW-1:0] cx;
    logic [CXW-1:0] cx_nxt;
    logic [CYW-1:0] cy;
    logic [CYW-1:0] cy_nxt;
    logic           valid;
    logic           valid_nxt;
    logic [8:0]     vga_x_nxt;
    logic [7:0]     vga_y_nxt;

    // One extra bit on each sum so a box hanging off the screen edge is
    // detected and clipped instead of wrapping to the opposite side.
    logic [9:0] sum_x;
    logic [8:0] sum_y;
    logic       in_range;

    assign sum_x    = {1'b0, x0_l} + 10'(cx);
    assign sum_y    = {1'b0, y0_l} + 9'(cy);
    assign in_range = (sum_x <= 10'(X_MAX)) && (sum_y <= 9'(Y_MAX));

    // Address is only meaningful while scanning; held at zero otherwise.
    assign rom_x = (state == SCAN) ? sum_x[8:0] : '0;
    assign rom_y = (state == SCAN) ? sum_y[7:0] : '0;

    // The registered address lines up with rom_q, which arrives one clock
    // after the address, so the colour passes straight through.
    assign vga_colour = rom_q;
    assign plot       = valid;
    assign busy       = (state == SCAN) || (state == FLUSH);
    assign done       = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            x0_l  <= '0;
            y0_l  <= '0;
            cx    <= '0;
            cy    <= '0;
            valid <= 1'b0;
            vga_x <= '0;
            vga_y <= '0;
        end else begin
            state <= state_nxt;
            x0_l  <= x0_l_nxt;
            y0_l  <= y0_l_nxt;
            cx    <= cx_nxt;
            cy    <= cy_nxt;
            valid <= valid_nxt;
            vga_x <= vga_x_nxt;
            vga_y <= vga_y_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x0_l_nxt  = x0_l;
        y0_l_nxt  = y0_l;
        cx_nxt    = cx;
        cy_nxt    = cy;
        valid_nxt = 1'b0;
        vga_x_nxt = vga_x;
        vga_y_nxt = vga_y;

        unique case (state)
            IDLE: begin
                if (start) begin
                    x0_l_nxt  = x0;
                    y0_l_nxt  = y0;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    state_nxt = SCAN;
                end
            end

            SCAN: begin
                // Clipped pixels still take their cycle, keeping the
                // total scan length fixed.
                valid_nxt = in_range;
                vga_x_nxt = sum_x[8:0];
                vga_y_nxt = sum_y[7:0];
                if (cx == CX_LAST) begin
                    cx_nxt = '0;
                    if (cy == CY_LAST) begin
                        cy_nxt    = '0;
                        state_nxt = FLUSH;
                    end else begin
                        cy_nxt = cy + 1'b1;
                    end
                end else begin
                    cx_nxt = cx + 1'b1;
                end
            end

            FLUSH: begin
                // Last pixel plots here; no new address is issued.
                state_nxt = DONE;
            end

            DONE: begin
                // start is deliberately not sampled here.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_background_restore.sv
// Bench for background_restore: a default-size instance and a 4x2 instance
// against a cycle-indexed reference model and a behavioural ROM.
module tb_background_restore;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    // default-size instance (suffix _a)
    logic       start_a = 1'b0;
    logic [8:0] x0_a = '0;
    logic [7:0] y0_a = '0;
    logic [8:0] rom_x_a;
    logic [7:0] rom_y_a;
    logic [2:0] rom_q_a;
    logic [8:0] vga_x_a;
    logic [7:0] vga_y_a;
    logic [2:0] vga_colour_a;
    logic       plot_a;
    logic       busy_a;
    logic       done_a;

    // 4x2 instance (suffix _s)
    logic       start_s = 1'b0;
    logic [8:0] x0_s = '0;
    logic [7:0] y0_s = '0;
    logic [8:0] rom_x_s;
    logic [7:0] rom_y_s;
    logic [2:0] rom_q_s;
    logic [8:0] vga_x_s;
    logic [7:0] vga_y_s;
    logic [2:0] vga_colour_s;
    logic       plot_s;
    logic       busy_s;
    logic       done_s;

    int n_cmp = 0;
    int n_bad = 0;
    int salt = 0;
    logic cur = 1'b0;

    always #5 clock = ~clock;

    background_restore dut_a (
        .clock(clock), .resetn(resetn), .start(start_a),
        .x0(x0_a), .y0(y0_a), .rom_x(rom_x_a), .rom_y(rom_y_a),
        .rom_q(rom_q_a), .vga_x(vga_x_a), .vga_y(vga_y_a),
        .vga_colour(vga_colour_a), .plot(plot_a), .busy(busy_a),
        .done(done_a)
    );

    background_restore #(.BOX_W(4), .BOX_H(2)) dut_s (
        .clock(clock), .resetn(resetn), .start(start_s),
        .x0(x0_s), .y0(y0_s), .rom_x(rom_x_s), .rom_y(rom_y_s),
        .rom_q(rom_q_s), .vga_x(vga_x_s), .vga_y(vga_y_s),
        .vga_colour(vga_colour_s), .plot(plot_s), .busy(busy_s),
        .done(done_s)
    );

    // Background picture: neighbouring addresses get different colours so
    // any misalignment between address and colour shows up.
    function automatic logic [2:0] colour_of(input logic [8:0] x,
                                             input logic [7:0] y);
        int t;
        t = int'(x) * 7 + int'(y) * 3 + salt;
        return t[2:0];
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rom_q_a <= '0;
            rom_q_s <= '0;
        end else begin
            rom_q_a <= colour_of(rom_x_a, rom_y_a);
            rom_q_s <= colour_of(rom_x_s, rom_y_s);
        end
    end

    logic       m_plot;
    logic       m_busy;
    logic       m_done;
    logic [8:0] m_vx;
    logic [7:0] m_vy;
    logic [2:0] m_col;

    assign m_plot = cur ? plot_s : plot_a;
    assign m_busy = cur ? busy_s : busy_a;
    assign m_done = cur ? done_s : done_a;
    assign m_vx   = cur ? vga_x_s : vga_x_a;
    assign m_vy   = cur ? vga_y_s : vga_y_a;
    assign m_col  = cur ? vga_colour_s : vga_colour_a;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic s, input int x,
                         input int y);
        if (sel) begin
            start_s = s;
            x0_s = 9'(x);
            y0_s = 8'(y);
        end else begin
            start_a = s;
            x0_a = 9'(x);
            y0_a = 8'(y);
        end
    endtask

    // Cycle k counts negedges after the accepting edge. Pixel p of the
    // row-major scan is addressed in cycle p+1 and plotted in cycle p+2;
    // FLUSH is cycle n+1, DONE cycle n+2, IDLE again from n+3.
    task automatic run_restore(input logic sel, input int x, input int y,
                               input bit hold, input bit glitch);
        int w, h, n, p, px, py, nplot, ecnt, vw, vh;
        logic eplot;
        w = sel ? 4 : 16;
        h = sel ? 2 : 12;
        n = w * h;
        cur = sel;
        vw = (320 - x < w) ? 320 - x : w;
        vh = (240 - y < h) ? 240 - y : h;
        ecnt = vw * vh;
        nplot = 0;
        @(negedge clock);
        drive(sel, 1'b1, x, y);
        @(posedge clock);
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clock);
            if (k == 1 && !hold) drive(sel, 1'b0, x, y);
            if (glitch && k == 3) drive(sel, 1'b1, (x + 77) % 320,
                                        (y + 33) % 240);
            if (glitch && k == 4) drive(sel, 1'b0, x, y);
            p = k - 2;
            px = x + (p % w);
            py = y + (p / w);
            eplot = (k >= 2) && (k <= n + 1) && (px <= 319) && (py <= 239);
            check($sformatf("busy@%0d", k), m_busy, k <= n + 1);
            check($sformatf("done@%0d", k), m_done, k == n + 2);
            check($sformatf("plot@%0d", k), m_plot, eplot);
            if (eplot) begin
                check($sformatf("vga_x@%0d", k), m_vx, px);
                check($sformatf("vga_y@%0d", k), m_vy, py);
                check($sformatf("colour@%0d", k), m_col,
                      colour_of(9'(px), 8'(py)));
            end
            if (m_plot === 1'b1) nplot++;
        end
        check("plot_count", nplot, ecnt);
    endtask

    initial begin
        bit found;
        salt = int'($urandom_range(0, 7));

        #12;
        check("rst_plot_a", plot_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_vga_x_a", vga_x_a, 0);
        check("rst_vga_y_a", vga_y_a, 0);
        check("rst_rom_x_a", rom_x_a, 0);
        check("rst_rom_y_a", rom_y_a, 0);
        check("rst_plot_s", plot_s, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_done_s", done_s, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // small box, fully visible
        run_restore(1'b1, 10, 20, 1'b0, 1'b0);
        // default box at the bottom-right corner: 2 visible pixels
        run_restore(1'b0, 318, 239, 1'b0, 1'b0);

        // random boxes, half biased toward the screen edges
        for (int i = 0; i < 6; i++) begin
            int rx, ry;
            if (i % 2 == 0) begin
                rx = int'($urandom_range(0, 319));
                ry = int'($urandom_range(0, 239));
            end else begin
                rx = int'($urandom_range(300, 319));
                ry = int'($urandom_range(226, 239));
            end
            run_restore(1'(i % 3 == 0), rx, ry, 1'b0, 1'b0);
        end

        // start held high: one IDLE cycle between done and next busy
        run_restore(1'b1, 50, 60, 1'b1, 1'b0);
        @(negedge clock);
        check("rehold_busy", busy_s, 1);
        drive(1'b1, 1'b0, 50, 60);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (done_s === 1'b1) found = 1'b1;
        end
        check("rehold_done", found, 1);

        // start pulsed mid-scan with other coordinates is ignored
        run_restore(1'b1, 200, 100, 1'b0, 1'b1);
        run_restore(1'b0, 120, 40, 1'b0, 1'b1);

        // reset in the 5th SCAN cycle
        cur = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 100, 100);
        @(posedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) drive(1'b0, 1'b0, 100, 100);
        end
        check("pre_rst_plot", plot_a, 1);
        check("pre_rst_busy", busy_a, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_plot", plot_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_rom_x", rom_x_a, 0);
        check("arst_vga_x", vga_x_a, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_hold_plot", plot_a, 0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("post_rst_busy%0d", i), busy_a, 0);
            check($sformatf("post_rst_plot%0d", i), plot_a, 0);
        end
        run_restore(1'b0, 305, 235, 1'b0, 1'b0);
        run_restore(1'b1, 316, 238, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
